// File: rtl/adder_pkg.sv
// Shared types and default sizing for the arbitrated adder.
package adder_pkg;

  localparam int unsigned DefNumReq  = 4;
  localparam int unsigned DefNumBits = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder: sum = a + b + cin, carry out of the MSB on cout.
module ripple_carry_adder #(
  parameter int unsigned NUM_BITS = 32
) (
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                cin,
  output logic [NUM_BITS-1:0] sum,
  output logic                cout
);

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_BITS; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Outer loop walks priority order from ptr; inner loop keeps all selects constant.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!any && req[j] && (((32'(ptr) + k) % NUM_REQ) == j)) begin
          gnt[j] = 1'b1;
          idx    = IdW'(j);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbitrated shared adder: one operation in flight, IDLE -> CALC -> RESP.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DefNumReq,
  parameter int unsigned NUM_BITS = DefNumBits
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_a,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [NUM_BITS-1:0]          rsp_sum,
  output logic                         rsp_cout,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         busy
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [IdW-1:0]      ptr_q;
  logic [IdW-1:0]      id_q;
  logic [NUM_BITS-1:0] a_q, b_q;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IdW-1:0]      pick_idx;
  logic                pick_any;
  logic [NUM_BITS-1:0] sel_a, sel_b;
  logic [NUM_BITS-1:0] add_sum;
  logic                add_cout;
  logic                accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  ripple_carry_adder #(
    .NUM_BITS (NUM_BITS)
  ) u_adder (
    .a    (a_q),
    .b    (b_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IdW'(i)) begin
        sel_a = req_a[i*NUM_BITS +: NUM_BITS];
        sel_b = req_b[i*NUM_BITS +: NUM_BITS];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_any) state_d = StCalc;
      StCalc:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; req_ready is also gated by rst_n so it reads zero while reset is held
  always_comb begin
    req_ready = '0;
    busy      = (state_q != StIdle);
    if (state_q == StIdle && rst_n) begin
      req_ready = pick_gnt;
    end
  end

  assign accept = (state_q == StIdle) && pick_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (accept) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= pick_idx;
        if (pick_idx == IdW'(NUM_REQ - 1)) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= pick_idx + IdW'(1);
        end
      end
      if (state_q == StCalc) begin
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state_q == StResp && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
